// File: rtl/save_mem_arbiter_pkg.sv
// Shared types for the save-RAM arbiter: core FSM states, read-return tags,
// and the bridge read-latency helper used to configure the data unloader.
package save_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        C_IDLE    = 2'd0,
        C_WAIT_RD = 2'd1,
        C_ACK     = 2'd2
    } core_state_e;

    // One entry per issued read; travels alongside the RAM latency.
    typedef struct packed {
        logic valid;
        logic is_bridge;
    } read_tag_t;

    // Cycles from a bridge_rd pulse to valid bridge_rd_data.
    function automatic int unsigned bridge_read_delay(input int unsigned mem_read_latency);
        return mem_read_latency + 32'd2;
    endfunction

endpackage

// File: rtl/save_mem_read_tag_pipe.sv
// Read-tag shift register. The tag of a read whose strobe is on the RAM port
// enters here and emerges DEPTH cycles later, aligned with mem_rdata.
//   clk_memory, reset : clock, async active-high reset (clears all tags)
//   tag_in            : tag of the read currently on mem_rd
//   tag_out           : tag belonging to the current mem_rdata
module save_mem_read_tag_pipe
    import save_mem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk_memory,
    input  logic      reset,
    input  read_tag_t tag_in,
    output read_tag_t tag_out
);

    read_tag_t [DEPTH-1:0] stage;

    always_ff @(posedge clk_memory or posedge reset) begin
        if (reset) begin
            stage <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/save_mem_arbiter.sv
// Arbitrates one fixed-latency save-RAM port between the APF bridge movers
// (loader write pulses, unloader read pulses) and the core (req/ack).
// Bridge accesses always win, so bridge read latency is constant.
// Optional statistics outputs are enabled by SAVE_MEM_ARBITER_STATS_EN.
//   bridge_wr*/bridge_rd*  : single-cycle loader/unloader pulses
//   bridge_rd_data         : unloader read data, valid MEM_READ_LATENCY+2 after pulse
//   core_req/we/addr/wdata : core request, held until core_ack
//   core_ack/core_rdata    : one-cycle completion with read data
//   mem_*                  : registered RAM port
//   err_collision          : sticky, loader and unloader pulsed together
//   stall_cycles/bridge_ops: (stats build only) saturating counters
module save_mem_arbiter
    import save_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = 17,
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned MEM_READ_LATENCY = 2
) (
    input  logic                  clk_memory,
    input  logic                  reset,
    input  logic                  bridge_wr,
    input  logic [ADDR_WIDTH-1:0] bridge_wr_addr,
    input  logic [DATA_WIDTH-1:0] bridge_wr_data,
    input  logic                  bridge_rd,
    input  logic [ADDR_WIDTH-1:0] bridge_rd_addr,
    output logic [DATA_WIDTH-1:0] bridge_rd_data,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_ack,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr,
    output logic                  mem_rd,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  err_collision
`ifdef SAVE_MEM_ARBITER_STATS_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           bridge_ops
`endif
);

    core_state_e           state;
    core_state_e           state_n;
    logic                  bridge_any;
    logic                  core_issue;
    logic                  core_tag;
    logic                  ack_set;
    logic                  rdata_load;
    logic                  iss_wr;
    logic                  iss_rd;
    logic                  iss_bridge;
    logic [ADDR_WIDTH-1:0] iss_addr;
    logic [DATA_WIDTH-1:0] iss_wdata;
    logic                  mem_rd_bridge;
    read_tag_t             tag_in;
    read_tag_t             tag_out;

    assign bridge_any = bridge_wr | bridge_rd;
    // core_ack high means the request still on core_req was just completed.
    assign core_issue = (state == C_IDLE) && core_req && !core_ack && !bridge_any;
    assign core_tag   = tag_out.valid && !tag_out.is_bridge;

    // Issue select: loader write, then unloader read, then core.
    always_comb begin
        iss_wr     = 1'b0;
        iss_rd     = 1'b0;
        iss_bridge = 1'b0;
        iss_addr   = mem_addr;
        iss_wdata  = mem_wdata;
        if (bridge_wr) begin
            iss_wr     = 1'b1;
            iss_bridge = 1'b1;
            iss_addr   = bridge_wr_addr;
            iss_wdata  = bridge_wr_data;
        end else if (bridge_rd) begin
            iss_rd     = 1'b1;
            iss_bridge = 1'b1;
            iss_addr   = bridge_rd_addr;
        end else if (core_issue) begin
            iss_wr    = core_we;
            iss_rd    = !core_we;
            iss_addr  = core_addr;
            iss_wdata = core_wdata;
        end
    end

    // Registered RAM port; strobes last exactly one cycle.
    always_ff @(posedge clk_memory or posedge reset) begin
        if (reset) begin
            mem_wr        <= 1'b0;
            mem_rd        <= 1'b0;
            mem_rd_bridge <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            mem_wr        <= iss_wr;
            mem_rd        <= iss_rd;
            mem_rd_bridge <= iss_bridge;
            mem_addr      <= iss_addr;
            mem_wdata     <= iss_wdata;
        end
    end

    always_comb begin
        tag_in.valid     = mem_rd;
        tag_in.is_bridge = mem_rd_bridge;
    end

    save_mem_read_tag_pipe #(
        .DEPTH (MEM_READ_LATENCY)
    ) u_tag_pipe (
        .clk_memory (clk_memory),
        .reset      (reset),
        .tag_in     (tag_in),
        .tag_out    (tag_out)
    );

    // Bridge return data and sticky collision flag.
    always_ff @(posedge clk_memory or posedge reset) begin
        if (reset) begin
            bridge_rd_data <= '0;
            err_collision  <= 1'b0;
        end else begin
            if (tag_out.valid && tag_out.is_bridge) begin
                bridge_rd_data <= mem_rdata;
            end
            if (bridge_wr && bridge_rd) begin
                err_collision <= 1'b1;
            end
        end
    end

    // Core FSM state register.
    always_ff @(posedge clk_memory or posedge reset) begin
        if (reset) begin
            state <= C_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Core FSM next state. A read sets the ack as its data is latched; a write
    // sets it from C_ACK, so C_ACK only acks when that has not happened yet.
    always_comb begin
        state_n    = state;
        ack_set    = 1'b0;
        rdata_load = 1'b0;
        case (state)
            C_IDLE: begin
                if (core_issue) begin
                    state_n = core_we ? C_ACK : C_WAIT_RD;
                end
            end
            C_WAIT_RD: begin
                if (core_tag) begin
                    rdata_load = 1'b1;
                    ack_set    = 1'b1;
                    state_n    = C_ACK;
                end
            end
            C_ACK: begin
                ack_set = !core_ack;
                state_n = C_IDLE;
            end
            default: begin
                state_n = C_IDLE;
            end
        endcase
    end

    // Core response registers.
    always_ff @(posedge clk_memory or posedge reset) begin
        if (reset) begin
            core_ack   <= 1'b0;
            core_rdata <= '0;
        end else begin
            core_ack <= ack_set;
            if (rdata_load) begin
                core_rdata <= mem_rdata;
            end
        end
    end

`ifdef SAVE_MEM_ARBITER_STATS_EN
    // Saturating activity counters.
    always_ff @(posedge clk_memory or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            bridge_ops   <= '0;
        end else begin
            if ((state == C_IDLE) && core_req && !core_ack && bridge_any &&
                (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (bridge_any && (bridge_ops != 32'hFFFF_FFFF)) begin
                bridge_ops <= bridge_ops + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_save_mem_arbiter.sv
// Directed bench for save_mem_arbiter with default parameters
// (ADDR_WIDTH=17, DATA_WIDTH=8, MEM_READ_LATENCY=2) and a 2-cycle RAM model.
module tb_save_mem_arbiter;

    localparam int unsigned AW = 17;
    localparam int unsigned DW = 8;

    logic          clk_memory;
    logic          reset;
    logic          bridge_wr;
    logic [AW-1:0] bridge_wr_addr;
    logic [DW-1:0] bridge_wr_data;
    logic          bridge_rd;
    logic [AW-1:0] bridge_rd_addr;
    logic [DW-1:0] bridge_rd_data;
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_ack;
    logic [DW-1:0] core_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_wr;
    logic          mem_rd;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          err_collision;
`ifdef SAVE_MEM_ARBITER_STATS_EN
    logic [31:0]   stall_cycles;
    logic [31:0]   bridge_ops;
`endif

    int   tests;
    int   fails;
    logic ack_seen;

    save_mem_arbiter dut (
        .clk_memory     (clk_memory),
        .reset          (reset),
        .bridge_wr      (bridge_wr),
        .bridge_wr_addr (bridge_wr_addr),
        .bridge_wr_data (bridge_wr_data),
        .bridge_rd      (bridge_rd),
        .bridge_rd_addr (bridge_rd_addr),
        .bridge_rd_data (bridge_rd_data),
        .core_req       (core_req),
        .core_we        (core_we),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .core_ack       (core_ack),
        .core_rdata     (core_rdata),
        .mem_addr       (mem_addr),
        .mem_wr         (mem_wr),
        .mem_rd         (mem_rd),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .err_collision  (err_collision)
`ifdef SAVE_MEM_ARBITER_STATS_EN
        ,
        .stall_cycles   (stall_cycles),
        .bridge_ops     (bridge_ops)
`endif
    );

    initial clk_memory = 1'b0;
    always #5 clk_memory = ~clk_memory;

    // RAM contents as seen by reads; unlisted addresses return addr ^ 0x5A.
    function automatic logic [DW-1:0] ram_read(input logic [AW-1:0] a);
        case (a)
            17'h00020: return 8'h3C;
            17'h1FFFF: return 8'h77;
            17'h00030: return 8'h91;
            17'h00040: return 8'hB4;
            17'h00050: return 8'hC5;
            default:   return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Two-cycle read pipe; 0xEE marks cycles with no read returning.
    logic [DW-1:0] rd_s1;
    logic [DW-1:0] rd_s2;
    always @(posedge clk_memory) begin
        rd_s1 <= mem_rd ? ram_read(mem_addr) : 8'hEE;
        rd_s2 <= rd_s1;
    end
    assign mem_rdata = rd_s2;

    task automatic tick();
        @(posedge clk_memory);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        ack_seen       = 1'b0;
        reset          = 1'b1;
        bridge_wr      = 1'b0;
        bridge_wr_addr = '0;
        bridge_wr_data = '0;
        bridge_rd      = 1'b0;
        bridge_rd_addr = '0;
        core_req       = 1'b0;
        core_we        = 1'b0;
        core_addr      = '0;
        core_wdata     = '0;

        // Reset state
        tick();
        tick();
        chk("rst_mem_wr",  32'(mem_wr), 32'h0);
        chk("rst_mem_rd",  32'(mem_rd), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_core_ack", 32'(core_ack), 32'h0);
        chk("rst_err",     32'(err_collision), 32'h0);
        reset = 1'b0;
        tick();

        // 1. Uncontended core write, accepted in cycle A
        core_req = 1'b1; core_we = 1'b1; core_addr = 17'h00010; core_wdata = 8'hA5;
        tick();
        chk("t1_mem_wr",    32'(mem_wr), 32'h1);
        chk("t1_mem_rd",    32'(mem_rd), 32'h0);
        chk("t1_mem_addr",  32'(mem_addr), 32'h10);
        chk("t1_mem_wdata", 32'(mem_wdata), 32'hA5);
        chk("t1_ack_a1",    32'(core_ack), 32'h0);
        tick();
        chk("t1_ack_a2",    32'(core_ack), 32'h1);
        chk("t1_mem_wr_a2", 32'(mem_wr), 32'h0);
        core_req = 1'b0;
        tick();
        chk("t1_ack_a3",    32'(core_ack), 32'h0);
        tick();

        // 2. Uncontended core read, ack at acceptance+4
        core_req = 1'b1; core_we = 1'b0; core_addr = 17'h00020;
        tick();
        chk("t2_mem_rd",   32'(mem_rd), 32'h1);
        chk("t2_mem_addr", 32'(mem_addr), 32'h20);
        tick();
        chk("t2_ack_b2",   32'(core_ack), 32'h0);
        tick();
        chk("t2_ack_b3",   32'(core_ack), 32'h0);
        tick();
        chk("t2_ack_b4",   32'(core_ack), 32'h1);
        chk("t2_rdata",    32'(core_rdata), 32'h3C);
        core_req = 1'b0;
        tick();
        chk("t2_ack_b5",   32'(core_ack), 32'h0);
        chk("t2_rdata_hold", 32'(core_rdata), 32'h3C);
        tick();

        // 3. Bridge read preempts a core read raised in the same cycle
        bridge_rd = 1'b1; bridge_rd_addr = 17'h1FFFF;
        core_req = 1'b1; core_we = 1'b0; core_addr = 17'h00030;
        tick();
        bridge_rd = 1'b0;
        chk("t3_brd_issue", 32'(mem_rd), 32'h1);
        chk("t3_brd_addr",  32'(mem_addr), 32'h1FFFF);
        tick();
        chk("t3_core_issue", 32'(mem_rd), 32'h1);
        chk("t3_core_addr",  32'(mem_addr), 32'h30);
        tick();
        chk("t3_brdata_c3", 32'(bridge_rd_data), 32'h0);
        chk("t3_ack_c3",    32'(core_ack), 32'h0);
        tick();
        chk("t3_brdata_c4", 32'(bridge_rd_data), 32'h77);
        chk("t3_ack_c4",    32'(core_ack), 32'h0);
        tick();
        chk("t3_ack_c5",    32'(core_ack), 32'h1);
        chk("t3_rdata",     32'(core_rdata), 32'h91);
        core_req = 1'b0;
        tick();
        tick();

        // 4. Core read in flight, bridge read one cycle later
        core_req = 1'b1; core_we = 1'b0; core_addr = 17'h00040;
        tick();
        chk("t4_core_addr", 32'(mem_addr), 32'h40);
        bridge_rd = 1'b1; bridge_rd_addr = 17'h00050;
        tick();
        bridge_rd = 1'b0;
        chk("t4_brd_issue", 32'(mem_rd), 32'h1);
        chk("t4_brd_addr",  32'(mem_addr), 32'h50);
        tick();
        chk("t4_ack_d3",    32'(core_ack), 32'h0);
        tick();
        chk("t4_ack_d4",    32'(core_ack), 32'h1);
        chk("t4_core_rdata", 32'(core_rdata), 32'hB4);
        chk("t4_brdata_d4", 32'(bridge_rd_data), 32'h77);
        core_req = 1'b0;
        tick();
        chk("t4_brdata_d5", 32'(bridge_rd_data), 32'hC5);
        chk("t4_core_rdata_hold", 32'(core_rdata), 32'hB4);
        chk("t4_ack_d5",    32'(core_ack), 32'h0);
        tick();

        // 5. Collision: write issued, read dropped, sticky error
        chk("t5_err_before", 32'(err_collision), 32'h0);
        bridge_wr = 1'b1; bridge_wr_addr = 17'h00060; bridge_wr_data = 8'hE7;
        bridge_rd = 1'b1; bridge_rd_addr = 17'h00070;
        tick();
        bridge_wr = 1'b0;
        bridge_rd = 1'b0;
        chk("t5_mem_wr",    32'(mem_wr), 32'h1);
        chk("t5_mem_rd",    32'(mem_rd), 32'h0);
        chk("t5_mem_addr",  32'(mem_addr), 32'h60);
        chk("t5_mem_wdata", 32'(mem_wdata), 32'hE7);
        chk("t5_err_set",   32'(err_collision), 32'h1);
        for (int i = 0; i < 5; i++) tick();
        chk("t5_err_sticky", 32'(err_collision), 32'h1);
        chk("t5_rd_dropped", 32'(bridge_rd_data), 32'hC5);

        // 6. Reset during C_WAIT_RD
        core_req = 1'b1; core_we = 1'b0; core_addr = 17'h00020;
        tick();
        chk("t6_mem_rd", 32'(mem_rd), 32'h1);
        reset    = 1'b1;
        core_req = 1'b0;
        #1;
        chk("t6_rst_mem_rd",   32'(mem_rd), 32'h0);
        chk("t6_rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("t6_rst_core_rdata", 32'(core_rdata), 32'h0);
        chk("t6_rst_brdata",   32'(bridge_rd_data), 32'h0);
        chk("t6_rst_err",      32'(err_collision), 32'h0);
        chk("t6_rst_wdata",    32'(mem_wdata), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (core_ack) ack_seen = 1'b1;
        end
        chk("t6_no_ack", 32'(ack_seen), 32'h0);
        core_req = 1'b1; core_we = 1'b1; core_addr = 17'h00080; core_wdata = 8'h5A;
        tick();
        chk("t6_mem_wr",   32'(mem_wr), 32'h1);
        chk("t6_mem_addr", 32'(mem_addr), 32'h80);
        tick();
        chk("t6_ack",      32'(core_ack), 32'h1);
        core_req = 1'b0;
        tick();
        chk("t6_ack_end",  32'(core_ack), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
